router_src_arbiter: RTL
=======================

Name: router_src_arbiter

Overview:
Shares the single router_top input port between 3 packet sources. It grants one source per packet in round-robin order and forwards the header and payload onto the router data_in/pkt_valid. It generates and appends the parity byte, checks the payload length against the header, and drops packets addressed to port 3. It sits directly in front of router_top and honours the router busy stall.

Parameters:
GAP_CYCLES, 2, idle cycles (pkt_valid=0) inserted after each forwarded parity byte before the next grant; legal range 1..15.

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  synchronous, active-high reset.
src_valid  in  3  bit i: source i presents a byte.
src_data  in  24  source i byte on bits [8i+7:8i]; the first byte of each packet is the header {len[5:0],addr[1:0]}.
src_last  in  3  bit i: the current byte is source i's final payload byte (the source never sends parity).
src_ready  out  3  bit i: source i byte accepted this cycle if src_valid[i]=1.
router_busy  in  1  router busy; the router takes no byte while it is high.
router_data_in  out  8  to router data_in.
router_pkt_valid  out  1  to router pkt_valid.
grant  out  3  one-hot owner of the current packet; 0 when idle.
pkt_done  out  1  1-cycle pulse when the parity byte is accepted by the router.
len_err  out  1  1-cycle pulse on a length mismatch.
addr_err  out  1  1-cycle pulse when a packet is dropped (addr=3 or len=0).
proto_err  out  1  1-cycle pulse when the owning source bubbles mid-packet.

Behaviour:
- Reset values: state IDLE; all outputs 0; rr_ptr=0, so source 0 has highest priority first. A reset asserted mid-packet aborts at once; no parity is sent.
- Byte transfer to router: rising edge with router_busy=0 while in HDR, PLD or PAR. Transfer from source g: rising edge with src_valid[g] & src_ready[g].
- src_ready[g] = grant[g] & ~router_busy in HDR/PLD. src_ready[g] = grant[g] in DROP/FLUSH. Otherwise 0. Non-granted sources always see 0.
- IDLE: if any src_valid is set, the next cycle registers grant to the first requester at or after rr_ptr (cyclic). State goes to HDR, or to DROP when the header has addr=2'b11 or len=0 (addr_err pulses on entry). Latency: request at cycle N gives grant and header on router_data_in at N+1.
- HDR: router_pkt_valid=1, router_data_in=src_data[g]. On transfer: parity<=header, cnt<=len. If src_last is set on the header: len_err, go PAR. Else go PLD.
- PLD: router_pkt_valid=1, router_data_in=src_data[g]. On transfer: parity^=byte, cnt-=1.
  - last & cnt==1: go PAR.
  - last & cnt!=1: len_err, go PAR. The short packet is forwarded as-is.
  - ~last & cnt==1: len_err, set flush flag, go PAR.
- PLD with router_busy=0 and src_valid[g]=0: proto_err pulses; pkt_valid stays 1. Sources must not bubble once granted.
- PAR: router_pkt_valid=0, router_data_in=parity. Holds until transfer; then pkt_done pulses. Next state is FLUSH if the flush flag is set, else GAP.
- FLUSH/DROP: router outputs 0. Source bytes are consumed (ready=1) and discarded until a byte with last. FLUSH then goes to GAP; DROP goes to IDLE.
- GAP: outputs 0 for GAP_CYCLES cycles, then IDLE.
- Leaving GAP or DROP: rr_ptr <= (g+1) mod 3, grant <= 0.
- Requests arriving during a packet wait; grant never changes mid-packet.
- Simultaneous requests: resolved strictly by rr_ptr.
- router_busy high in PAR: parity is held stable.
- len counter is 6-bit; the maximum packet is 63 payload bytes.

Test Plan:
- Single packet: src1 sends header 0x39 (len 14, addr 1) plus 14 bytes, last on the 14th, busy=0 → grant=3'b010. pkt_valid=1 for 15 cycles, then a parity cycle with pkt_valid=0 and data = XOR of all 15 bytes. pkt_done pulses once, then 2 idle cycles.
- Round-robin: all 3 sources request continuously with len-2 packets → grant order src0, src1, src2, src0. No source is granted twice in a row.
- Busy stall: busy=1 for 5 cycles mid-payload and 3 cycles in PAR → src_ready=0 and router_data_in held during the stalls. The byte count and parity are still correct, and there is exactly one pkt_done.
- Bad address: src2 header 0x0B (len 2, addr 3) → addr_err pulse, 3 bytes consumed, router_pkt_valid stays 0, and the next grant goes to src0.
- Length mismatch: header len 4 with last on payload byte 2 → len_err, parity sent after 2 bytes. Header len 2 with last on byte 4 → len_err, parity after byte 2, bytes 3 and 4 flushed.
- Reset mid-payload (cycle 6): all outputs 0 the next cycle. A fresh src0 request is then granted first.

Source files
------------

// File: rtl/router_src_arbiter.sv
// router_src_arbiter: round-robin front end for router_top.
// Grants one of three byte sources per packet, forwards header and payload
// onto the router port, appends the parity byte, checks the payload length
// against the header and drops packets to port 3 or with zero length.
module router_src_arbiter #(
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [2:0]  src_valid,
    input  logic [23:0] src_data,
    input  logic [2:0]  src_last,
    output logic [2:0]  src_ready,
    input  logic        router_busy,
    output logic [7:0]  router_data_in,
    output logic        router_pkt_valid,
    output logic [2:0]  grant,
    output logic        pkt_done,
    output logic        len_err,
    output logic        addr_err,
    output logic        proto_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_PLD,
        S_PAR,
        S_FLUSH,
        S_DROP,
        S_GAP
    } state_t;

    state_t      state_q;
    logic [1:0]  rr_q;
    logic [1:0]  gsel_q;
    logic [2:0]  grant_q;
    logic [7:0]  parity_q;
    logic [5:0]  cnt_q;
    logic        flush_q;
    logic [3:0]  gap_q;
    logic        pkt_done_q;
    logic        len_err_q;
    logic        addr_err_q;
    logic        proto_err_q;

    logic [1:0]  pick_d;
    logic        found_d;
    logic [1:0]  scan_d;
    logic [7:0]  pick_hdr;
    logic [7:0]  cur_data;
    logic        cur_valid;
    logic        cur_last;
    logic        hdr_drop;

    function automatic logic [1:0] next_src(input logic [1:0] i);
        return (i == 2'd2) ? 2'd0 : i + 2'd1;
    endfunction

    function automatic logic [7:0] byte_sel(input logic [23:0] d, input logic [1:0] i);
        case (i)
            2'd0:    return d[7:0];
            2'd1:    return d[15:8];
            2'd2:    return d[23:16];
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [2:0] onehot(input logic [1:0] i);
        return 3'b001 << i;
    endfunction

    // First requester at or after the round-robin pointer, cyclically.
    always_comb begin
        pick_d  = rr_q;
        found_d = 1'b0;
        scan_d  = rr_q;
        for (int unsigned k = 0; k < 3; k++) begin
            if (!found_d && src_valid[scan_d]) begin
                pick_d  = scan_d;
                found_d = 1'b1;
            end
            scan_d = next_src(scan_d);
        end
    end

    assign pick_hdr  = byte_sel(src_data, pick_d);
    assign hdr_drop  = (pick_hdr[1:0] == 2'b11) || (pick_hdr[7:2] == 6'd0);
    assign cur_data  = byte_sel(src_data, gsel_q);
    assign cur_valid = src_valid[gsel_q];
    assign cur_last  = src_last[gsel_q];

    // Source handshake and router-side data path decoded from the state.
    always_comb begin
        src_ready        = '0;
        router_pkt_valid = 1'b0;
        router_data_in   = '0;
        case (state_q)
            S_HDR, S_PLD: begin
                src_ready        = grant_q & {3{~router_busy}};
                router_pkt_valid = 1'b1;
                router_data_in   = cur_data;
            end
            S_PAR: begin
                router_data_in = parity_q;
            end
            S_DROP, S_FLUSH: begin
                src_ready = grant_q;
            end
            default: ;
        endcase
    end

    // Packet sequencing FSM with registered grant and status pulses.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            rr_q        <= '0;
            gsel_q      <= '0;
            grant_q     <= '0;
            parity_q    <= '0;
            cnt_q       <= '0;
            flush_q     <= 1'b0;
            gap_q       <= '0;
            pkt_done_q  <= 1'b0;
            len_err_q   <= 1'b0;
            addr_err_q  <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            pkt_done_q  <= 1'b0;
            len_err_q   <= 1'b0;
            addr_err_q  <= 1'b0;
            proto_err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (found_d) begin
                        gsel_q  <= pick_d;
                        grant_q <= onehot(pick_d);
                        if (hdr_drop) begin
                            state_q    <= S_DROP;
                            addr_err_q <= 1'b1;
                        end else begin
                            state_q <= S_HDR;
                        end
                    end
                end
                S_HDR: begin
                    if (cur_valid && !router_busy) begin
                        parity_q <= cur_data;
                        cnt_q    <= cur_data[7:2];
                        flush_q  <= 1'b0;
                        if (cur_last) begin
                            len_err_q <= 1'b1;
                            state_q   <= S_PAR;
                        end else begin
                            state_q <= S_PLD;
                        end
                    end
                end
                S_PLD: begin
                    if (!router_busy) begin
                        if (cur_valid) begin
                            parity_q <= parity_q ^ cur_data;
                            cnt_q    <= cnt_q - 6'd1;
                            if (cur_last) begin
                                if (cnt_q != 6'd1) len_err_q <= 1'b1;
                                state_q <= S_PAR;
                            end else if (cnt_q == 6'd1) begin
                                // Header length reached before last: drain the rest after parity.
                                len_err_q <= 1'b1;
                                flush_q   <= 1'b1;
                                state_q   <= S_PAR;
                            end
                        end else begin
                            proto_err_q <= 1'b1;
                        end
                    end
                end
                S_PAR: begin
                    if (!router_busy) begin
                        pkt_done_q <= 1'b1;
                        gap_q      <= 4'(GAP_CYCLES - 1);
                        state_q    <= flush_q ? S_FLUSH : S_GAP;
                    end
                end
                S_FLUSH: begin
                    if (cur_valid && cur_last) begin
                        gap_q   <= 4'(GAP_CYCLES - 1);
                        state_q <= S_GAP;
                    end
                end
                S_DROP: begin
                    if (cur_valid && cur_last) begin
                        rr_q    <= next_src(gsel_q);
                        grant_q <= '0;
                        state_q <= S_IDLE;
                    end
                end
                S_GAP: begin
                    if (gap_q == 4'd0) begin
                        rr_q    <= next_src(gsel_q);
                        grant_q <= '0;
                        state_q <= S_IDLE;
                    end else begin
                        gap_q <= gap_q - 4'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign grant     = grant_q;
    assign pkt_done  = pkt_done_q;
    assign len_err   = len_err_q;
    assign addr_err  = addr_err_q;
    assign proto_err = proto_err_q;

endmodule
